// File: rtl/restador_serial.sv
`default_nettype none
// ============================================================================
//  Module      : restador_serial
//  Description : Bit-serial unsigned subtractor, result = num1 - num2 (mod 2^N),
//                one bit per clock LSB first, single borrow flip-flop,
//                start/done handshake, result held until the next completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module restador_serial #(
   parameter int N = 6
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] num1,
   input  logic [N-1:0] num2,
   output logic [N-1:0] result,
   output logic         b_o,
   output logic         z_o,
   output logic         busy,
   output logic         done
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] C_LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   logic [N-1:0]    r_a;
   logic [N-1:0]    r_b;
   logic [N-1:0]    r_r;
   logic            r_bw;
   logic [CW-1:0]   r_cnt;

   logic            w_d;
   logic            w_bw_next;
   logic [N-1:0]    w_r_next;

   // One full-subtractor slice on the current LSBs; the new difference bit
   // enters R from the top so after N shifts bit 0 sits at R[0].
   always_comb begin
      w_d       = r_a[0] ^ r_b[0] ^ r_bw;
      w_bw_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_bw);
      w_r_next  = {w_d, r_r[N-1:1]};
   end

   // Control FSM and datapath; outputs are registered and only the final
   // RUN edge updates result/b_o/z_o.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_r     <= '0;
         r_bw    <= 1'b0;
         r_cnt   <= '0;
         result  <= '0;
         b_o     <= 1'b0;
         z_o     <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  r_a     <= num1;
                  r_b     <= num2;
                  r_bw    <= 1'b0;
                  r_cnt   <= '0;
                  busy    <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_r   <= w_r_next;
               r_a   <= {1'b0, r_a[N-1:1]};
               r_b   <= {1'b0, r_b[N-1:1]};
               r_bw  <= w_bw_next;
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == C_LAST) begin
                  result  <= w_r_next;
                  b_o     <= w_bw_next;
                  z_o     <= (w_r_next == '0);
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               done    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_restador_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_restador_serial
//  Description : Directed self-checking bench for restador_serial (N = 6).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_restador_serial;

   localparam int N = 6;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [N-1:0] num1  = '0;
   logic [N-1:0] num2  = '0;
   logic [N-1:0] result;
   logic         b_o;
   logic         z_o;
   logic         busy;
   logic         done;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   restador_serial #(.N(N)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .num1   (num1),
      .num2   (num2),
      .result (result),
      .b_o    (b_o),
      .z_o    (z_o),
      .busy   (busy),
      .done   (done)
   );

   // Single comparison point: counts the check and reports a mismatch.
   task automatic check_val(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Issue one operation from IDLE and check the completion.
   // full=1 also checks busy on every RUN cycle and done timing.
   task automatic run_op(input int a, input int b, input int er, input int eb,
                         input int ez, input bit full);
      @(negedge clk);
      num1  = N'(a);
      num2  = N'(b);
      start = 1'b1;
      @(posedge clk);                 // accept edge E0
      @(negedge clk);
      start = 1'b0;
      num1  = '0;                     // operands may change after accept
      num2  = '0;
      for (int k = 0; k < N; k++) begin
         if (full) begin
            check_val("busy_run", int'(busy), 1);
            check_val("done_run", int'(done), 0);
         end
         if (k < N - 1) @(negedge clk);
      end
      @(negedge clk);                 // after EN: DONE
      check_val("done_pulse", int'(done), 1);
      if (full) check_val("busy_done", int'(busy), 0);
      check_val("result", int'(result), er);
      check_val("b_o", int'(b_o), eb);
      check_val("z_o", int'(z_o), ez);
      @(negedge clk);                 // back in IDLE
      if (full) check_val("done_low", int'(done), 0);
   endtask

   initial begin
      int ndone;
      int first_i;
      int last_i;
      int bad_gap;
      int bad_hold;
      int consec;
      bit prev_done;

      // Reset state
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_val("rst_result", int'(result), 0);
      check_val("rst_b", int'(b_o), 0);
      check_val("rst_z", int'(z_o), 0);
      check_val("rst_busy", int'(busy), 0);
      check_val("rst_done", int'(done), 0);
      rst_n = 1'b1;

      // Directed operations
      run_op(63, 2, 61, 0, 0, 1'b1);
      run_op(2, 63, 3, 1, 0, 1'b1);
      run_op(60, 60, 0, 0, 1, 1'b1);
      run_op(0, 1, 63, 1, 0, 1'b1);

      // Start raised mid-RUN is ignored: 63-5 then a 1-1 request
      @(negedge clk);
      num1 = 6'd63; num2 = 6'd5; start = 1'b1;
      @(posedge clk);
      @(negedge clk);                 // after E0
      start = 1'b0;
      @(negedge clk);                 // after E1
      @(negedge clk);                 // after E2
      num1 = 6'd1; num2 = 6'd1; start = 1'b1;
      @(negedge clk);
      @(negedge clk);                 // after E4
      start = 1'b0;
      ndone = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            check_val("ign_result", int'(result), 58);
         end
      end
      check_val("ign_done_cnt", ndone, 1);
      repeat (4) @(negedge clk);
      check_val("ign_hold", int'(result), 58);
      check_val("ign_idle", int'(busy), 0);

      // Start held high continuously: 60-3, repeating every N+2 clocks
      @(negedge clk);
      num1 = 6'd60; num2 = 6'd3; start = 1'b1;
      ndone = 0; first_i = -1; last_i = -1; bad_gap = 0; bad_hold = 0;
      consec = 0; prev_done = 1'b0;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         if (done && prev_done) consec++;
         prev_done = done;
         if (done) begin
            if (first_i < 0) first_i = i;
            else if (i - last_i != N + 2) bad_gap++;
            last_i = i;
            ndone++;
         end
         if (first_i >= 0 && result !== 6'd57) bad_hold++;
      end
      start = 1'b0;
      check_val("hold_first", first_i, N);
      check_val("hold_pulses", ndone, 4);
      check_val("hold_gap", bad_gap, 0);
      check_val("hold_stable", bad_hold, 0);
      check_val("hold_consec", consec, 0);
      repeat (10) @(negedge clk);

      // Reset during RUN cycle 3 of 63-2
      @(negedge clk);
      num1 = 6'd63; num2 = 6'd2; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);                 // after E1
      @(negedge clk);                 // after E2
      rst_n = 1'b0;
      @(negedge clk);                 // after E3 with reset applied
      rst_n = 1'b1;
      check_val("ar_result", int'(result), 0);
      check_val("ar_b", int'(b_o), 0);
      check_val("ar_z", int'(z_o), 0);
      check_val("ar_busy", int'(busy), 0);
      check_val("ar_done", int'(done), 0);
      ndone = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check_val("ar_no_done", ndone, 0);
      run_op(10, 4, 6, 0, 0, 1'b1);

      // Exhaustive sweep against the arithmetic model
      for (int a = 0; a < 64; a++) begin
         for (int b = 0; b < 64; b++) begin
            int er;
            er = (a - b) & 63;
            run_op(a, b, er, (a < b) ? 1 : 0, (er == 0) ? 1 : 0, 1'b0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/restador_serial.md
# restador_serial

Bit-serial subtractor computing `num1 - num2` one bit per clock, LSB first, with a single borrow flip-flop. It is the inverse-direction companion to the team's parallel `sumador` adder and shares its operand and result port naming. It is intended for the lab ALU datapath where area matters more than latency. It uses a start/done handshake and holds its result until the next accepted operation.

## Interface
- `N`, default 6: operand and result width in bits; legal range N >= 2.
- `clk` input, 1 bit: clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: reset; synchronous, active-low.
- `start` input, 1 bit: request an operation; sampled only in IDLE.
- `num1` input, N bits: minuend, unsigned; captured on the accepting edge.
- `num2` input, N bits: subtrahend, unsigned; captured on the accepting edge.
- `result` output, N bits: `(num1 - num2) mod 2^N`; registered.
- `b_o` output, 1 bit: borrow out; 1 when num1 < num2 (unsigned).
- `z_o` output, 1 bit: 1 when result == 0.
- `busy` output, 1 bit: high while in RUN.
- `done` output, 1 bit: one-cycle pulse while in DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: on an edge with `start`=1, latch num1 and num2 into shift registers A and B, clear the borrow FF, clear bit counter `cnt` (width $clog2(N)), and go to RUN. With `start`=0, stay in IDLE.
- RUN, each edge:
  - d = A[0] ^ B[0] ^ bw
  - bw_next = (~A[0] & B[0]) | (~(A[0] ^ B[0]) & bw)
  - shift d into the MSB of internal register R (right shift); shift A and B right by one
  - cnt++
- When `cnt` == N-1, the edge processes the final bit and moves to DONE. On that same edge, copy the final R into `result`, set `b_o` = bw_next and `z_o` = (final R == 0).
- DONE: lasts one cycle with `done`=1, then goes to IDLE unconditionally.
- `start` is ignored in RUN and DONE; no queuing. A start held high through DONE is accepted on the first IDLE edge.
- `result`, `b_o` and `z_o` change only on the RUN->DONE edge. They hold their value through IDLE and through the following RUN until the next completion.
- num1 and num2 may change freely after the accepting edge.
- Arithmetic: unsigned, modulo 2^N. Two's-complement interpretation is left to the consumer: `b_o`=1 means a negative true difference.

## Timing
- Reset (`rst_n`=0 at an edge): state is IDLE; `result`=0, `b_o`=0, `z_o`=0, `busy`=0, `done`=0; internal A, B, R, bw and cnt are cleared.
- Reset has priority over every other event. Reset mid-RUN or in DONE aborts the operation with no `done` pulse.
- Accept edge E0 is followed by RUN edges E1..EN. The EN edge enters DONE, so `done` and the new `result` are visible after EN. Latency from accept edge to done = N clocks.
- `busy`=1 from after E0 through the cycle ending at EN; `busy`=0 in DONE.
- Minimum spacing between accept edges is N+2 clocks: N RUN cycles, 1 DONE cycle, then 1 IDLE sample.
- `done` is never high for two consecutive cycles.

## Test plan
- Reset, then N=6, num1=63, num2=2, pulse start: `busy` stays high for 6 cycles, `done` pulses 6 clocks after the accept edge, result=61, b_o=0, z_o=0.
- num1=2, num2=63: result=3, b_o=1, z_o=0. Then num1=60, num2=60: result=0, b_o=0, z_o=1. Then num1=0, num2=1: result=63, b_o=1.
- Raise start again 2 cycles into a 63-5 operation with num1=1, num2=1: the second request is ignored, result=58, only one `done` pulse, and `result` holds 58 until a later accepted start.
- Hold start=1 continuously with num1=60, num2=3: the first result is 57; `done` pulses repeat every N+2=8 clocks; `result` stays stable between pulses.
- Assert rst_n=0 for one edge at RUN cycle 3 of 63-2: no `done`, all outputs 0, state IDLE. A new start of 10-4 then yields result=6 after 6 clocks.
- Sweep all 4096 operand pairs at N=6 against a `(num1 - num2) & 63` and `num1 < num2` model; zero mismatches required.
